// File: rtl/operand_fetch_pkg.sv
// Shared types for operand_fetch: widths, FSM state codes, ID/EX register bundle
// and the operand select helper.
package operand_fetch_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // FSM state codes (RUN, BUBBLE)
  typedef logic [0:0] of_state_t;
  localparam of_state_t RUN    = 1'b0;
  localparam of_state_t BUBBLE = 1'b1;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } idex_t;

  // x0 always reads zero regardless of regfile or writeback contents.
  function automatic logic [XLEN-1:0] select_operand(
    input logic [REGW-1:0] rs,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_hit,
    input logic [XLEN-1:0] wb_data
  );
    if (rs == '0) return '0;
    if (wb_hit) return wb_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/operand_fetch_hazard_detect.sv
// Combinational hazard compare for operand_fetch: load-use against EX, plus the
// writeback/read collision when OPERAND_FETCH_WB_BYPASS_EN is not defined.
module operand_fetch_hazard_detect
  import operand_fetch_pkg::*;
(
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [REGW-1:0] ex_rd,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  output logic            wb_hit1,
  output logic            wb_hit2,
  output logic            hazard
);

  logic load_use;

  assign wb_hit1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
  assign wb_hit2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);

  assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  assign hazard = load_use;
`else
  // Without the bypass mux a same-cycle writeback would be missed, so wait a cycle.
  logic wb_hazard;
  assign wb_hazard = id_valid && ((id_use_rs1 && wb_hit1) || (id_use_rs2 && wb_hit2));
  assign hazard    = load_use || wb_hazard;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Decode-side operand fetch: regfile read, writeback bypass, load-use bubble and
// the ID/EX register. Optional feature macro: OPERAND_FETCH_WB_BYPASS_EN.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  output logic [REGW-1:0] rf_rs1,
  output logic [REGW-1:0] rf_rs2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic [REGW-1:0] ex_rs1,
  output logic [REGW-1:0] ex_rs2,
  output logic [REGW-1:0] ex_rd,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [0:0]      fsm_state
);

  // Handshake: decode presents an instruction while id_valid is high and it is
  // consumed on every cycle where id_stall is low; while id_stall is high decode
  // must hold all id_* inputs unchanged.

  idex_t           ex_q;
  of_state_t       state;
  logic            hazard;
  logic            take_bubble;
  logic            wb_hit1;
  logic            wb_hit2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign rf_rs1 = id_rs1;
  assign rf_rs2 = id_rs2;

  operand_fetch_hazard_detect u_hazard (
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_valid     (ex_q.valid),
    .ex_mem_read  (ex_q.mem_read),
    .ex_rd        (ex_q.rd),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_hit1      (wb_hit1),
    .wb_hit2      (wb_hit2),
    .hazard       (hazard)
  );

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  assign op1 = select_operand(id_rs1, rf_rd1, wb_hit1, wb_wd);
  assign op2 = select_operand(id_rs2, rf_rd2, wb_hit2, wb_wd);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wd, wb_hit1, wb_hit2};
  assign op1 = select_operand(id_rs1, rf_rd1, 1'b0, wb_wd);
  assign op2 = select_operand(id_rs2, rf_rd2, 1'b0, wb_wd);
`endif

  // A hazard is only acted on from RUN; BUBBLE lets the held instruction through.
  assign take_bubble = (state == RUN) && hazard;
  assign id_stall    = !rst && !flush && (ex_stall || take_bubble);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      state <= RUN;
    end else if (flush) begin
      ex_q.valid     <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
      state          <= RUN;
    end else if (ex_stall) begin
      ex_q  <= ex_q;
      state <= state;
    end else if (take_bubble) begin
      ex_q.valid     <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
      state          <= BUBBLE;
    end else begin
      ex_q.valid     <= id_valid;
      ex_q.reg_write <= id_valid && id_reg_write;
      ex_q.mem_read  <= id_valid && id_mem_read;
      ex_q.rs1       <= id_rs1;
      ex_q.rs2       <= id_rs2;
      ex_q.rd        <= id_rd;
      ex_q.op1       <= op1;
      ex_q.op2       <= op2;
      state          <= RUN;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_op1       = ex_q.op1;
  assign ex_op2       = ex_q.op2;
  assign fsm_state    = state;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed test-plan steps then random traffic, all
// checked against a cycle-level reference model of the ID/EX stage.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [4:0]  id_rs1, id_rs2, id_rd, rf_rs1, rf_rs2, wb_rd, ex_rs1, ex_rs2, ex_rd;
  logic [31:0] rf_rd1, rf_rd2, wb_wd, ex_op1, ex_op2;
  logic        wb_reg_write, ex_stall, flush, id_stall;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [0:0]  fsm_state;

  logic [31:0] regs [32];
  int          checks = 0;
  int          failures = 0;
  logic        last_stall = 1'b0;

  // reference model of the ID/EX register and the "bubble already paid" flag
  logic        m_valid, m_rw, m_mr, m_bubbled;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_op1, m_op2;

  // ---------------- clock / reset / regfile ----------------
  always #5 clk = ~clk;

  assign rf_rd1 = (rf_rs1 == 5'd0) ? 32'd0 : regs[rf_rs1];
  assign rf_rd2 = (rf_rs2 == 5'd0) ? 32'd0 : regs[rf_rs2];

  always @(posedge clk)
    if (wb_reg_write && wb_rd != 5'd0) regs[wb_rd] <= wb_wd;

  operand_fetch dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (BYP && wb_reg_write && wb_rd == rs) return wb_wd;
    return regs[rs];
  endfunction

  function automatic logic reads(input logic [4:0] r);
    return id_valid && ((id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r));
  endfunction

  // One clock: inputs already driven at posedge+2. Checks combinational outputs
  // just before the edge, advances the model, checks registered outputs after.
  task automatic cycle();
    logic load_use, wb_clash, hz, e_stall;
    logic [31:0] o1, o2;
    #6;
    load_use = m_valid && m_mr && m_rd != 5'd0 && reads(m_rd);
    wb_clash = !BYP && wb_reg_write && wb_rd != 5'd0 && reads(wb_rd);
    hz       = (load_use || wb_clash) && !m_bubbled;
    e_stall  = !rst && !flush && (ex_stall || hz);
    check("id_stall", {31'd0, id_stall}, {31'd0, e_stall});
    check("rf_rs1", {27'd0, rf_rs1}, {27'd0, id_rs1});
    check("rf_rs2", {27'd0, rf_rs2}, {27'd0, id_rs2});
    last_stall = id_stall;
    o1 = ref_operand(id_rs1);
    o2 = ref_operand(id_rs2);
    if (rst) begin
      {m_valid, m_rw, m_mr, m_bubbled} = '0;
      {m_rs1, m_rs2, m_rd, m_op1, m_op2} = '0;
    end else if (flush) begin
      {m_valid, m_rw, m_mr, m_bubbled} = '0;
    end else if (ex_stall) begin
      // everything holds
    end else if (hz) begin
      {m_valid, m_rw, m_mr} = '0;
      m_bubbled = 1'b1;
    end else begin
      m_valid = id_valid;
      m_rw = id_valid && id_reg_write;
      m_mr = id_valid && id_mem_read;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_op1 = o1; m_op2 = o2;
      m_bubbled = 1'b0;
    end
    @(posedge clk);
    #1;
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_rw});
    check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mr});
    check("ex_rs1", {27'd0, ex_rs1}, {27'd0, m_rs1});
    check("ex_rs2", {27'd0, ex_rs2}, {27'd0, m_rs2});
    check("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
    check("ex_op1", ex_op1, m_op1);
    check("ex_op2", ex_op2, m_op2);
    check("fsm_state", {31'd0, fsm_state}, {31'd0, m_bubbled});
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] wd);
    wb_reg_write = we; wb_rd = rd; wb_wd = wd;
  endtask

  task automatic drive_random();
    if (!last_stall)
      set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 1'($urandom),
             5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
             1'($urandom), $urandom_range(0, 9) < 4);
    set_wb($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
    ex_stall = $urandom_range(0, 9) == 0;
    flush    = $urandom_range(0, 19) == 0;
    rst      = $urandom_range(0, 99) == 0;
  endtask

  // ---------------- directed steps then random ----------------
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    regs[3] = 32'h11;
    regs[5] = 32'h1234;
    rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    {m_valid, m_rw, m_mr, m_bubbled} = '0;
    {m_rs1, m_rs2, m_rd, m_op1, m_op2} = '0;
    @(posedge clk); #2;

    // reset
    cycle();
    check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_ex_op1", ex_op1, 32'd0);
    rst = 1'b0;

    // basic read: x3 = 0x11, x0
    set_id(1, 5'd3, 1, 5'd0, 1, 5'd1, 1, 0);
    cycle();
    check("basic_op1", ex_op1, 32'h11);
    check("basic_op2", ex_op2, 32'd0);
    check("basic_valid", {31'd0, ex_valid}, 32'd1);

    // same-cycle writeback x5 = 0xDEAD
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd2, 1, 0);
    set_wb(1, 5'd5, 32'hDEAD);
    cycle();
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    check("wb_bypass_op1", ex_op1, 32'hDEAD);
`else
    check("wb_clash_stall", {31'd0, last_stall}, 32'd1);
    check("wb_clash_bubble", {31'd0, ex_valid}, 32'd0);
    set_wb(0, 0, 0);
    cycle();
    check("wb_after_op1", ex_op1, 32'hDEAD);
`endif
    set_wb(0, 0, 0);

    // load x7 then use rs2=7: one bubble
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    cycle();
    set_id(1, 5'd1, 1, 5'd7, 1, 5'd8, 1, 0);
    cycle();
    check("lu_stall", {31'd0, last_stall}, 32'd1);
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    cycle();
    check("lu_issue_stall", {31'd0, last_stall}, 32'd0);
    check("lu_issue_valid", {31'd0, ex_valid}, 32'd1);

    // load x7 then rs2=7 but unused: no stall
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    cycle();
    set_id(1, 5'd1, 1, 5'd7, 0, 5'd8, 1, 0);
    cycle();
    check("lu_unused_stall", {31'd0, last_stall}, 32'd0);

    // load to x0 then rs1=0; wb to x0 ignored
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
    cycle();
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 0);
    set_wb(1, 5'd0, 32'hFFFF);
    cycle();
    check("x0_stall", {31'd0, last_stall}, 32'd0);
    check("x0_op1", ex_op1, 32'd0);
    set_wb(0, 0, 0);

    // ex_stall held for 3 cycles
    set_id(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
    cycle();
    ex_stall = 1'b1;
    set_id(1, 5'd6, 1, 5'd6, 1, 5'd6, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("exstall_stall", {31'd0, last_stall}, 32'd1);
      check("exstall_op1", ex_op1, 32'h11);
    end
    ex_stall = 1'b0;
    cycle();

    // flush during the hazard cycle
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    cycle();
    set_id(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
    flush = 1'b1;
    cycle();
    check("flush_stall", {31'd0, last_stall}, 32'd0);
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_fsm", {31'd0, fsm_state}, 32'd0);
    flush = 1'b0;
    cycle();
    check("flush_next_valid", {31'd0, ex_valid}, 32'd1);

    // reset while in BUBBLE
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    cycle();
    set_id(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
    cycle();
    check("pre_rst_fsm", {31'd0, fsm_state}, 32'd1);
    rst = 1'b1;
    cycle();
    check("rst_bubble_fsm", {31'd0, fsm_state}, 32'd0);
    check("rst_bubble_rd", {27'd0, ex_rd}, 32'd0);
    rst = 1'b0;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      drive_random();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-side register-file reader for the pipelined core. Drives the regfile read addresses, bypasses same-cycle writeback data, detects load-use hazards and loads the ID/EX operand pipeline register. Sits between the decoder and the EX stage, opposite the writeback port that writes the regfile.

## Interface
- XLEN, 32, operand width
- REGW, 5, register index width
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1, id_rs2, id_rd  in  REGW  source and destination indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_reg_write, id_mem_read  in  1  instruction writes rd / is a load
- rf_rs1, rf_rs2  out  REGW  regfile read addresses (combinational = id_rs1/id_rs2)
- rf_rd1, rf_rd2  in  XLEN  regfile read data (x0 already reads 0)
- wb_reg_write  in  1, wb_rd  in  REGW, wb_wd  in  XLEN  writeback port (same values as the regfile write port)
- ex_stall  in  1  EX cannot accept; hold ID/EX register
- flush  in  1  branch redirect; kill ID/EX contents
- id_stall  out  1  decode/fetch must hold this cycle
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered control
- ex_rs1, ex_rs2, ex_rd  out  REGW  registered indices (for EX forwarding)
- ex_op1, ex_op2  out  XLEN  registered operand values

## Operation
- Operand select per source: if `wb_reg_write && wb_rd != 0 && wb_rd == rs`, use wb_wd; else rf_rdN. Index 0 always yields 0.
- Load-use hazard: `ex_valid && ex_mem_read && ex_rd != 0 && id_valid && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))`.
- FSM states RUN, BUBBLE:
  - RUN: hazard and !ex_stall -> insert bubble (ex_valid=0, control cleared), id_stall=1, go BUBBLE.
  - BUBBLE: one cycle; the load has left EX, so the instruction advances normally; return to RUN.
  - Without a hazard, RUN stays in RUN.
- Update priority per cycle: rst > flush > ex_stall > hazard bubble > advance.
  - flush: ex_valid, ex_reg_write and ex_mem_read go to 0; FSM -> RUN; id_stall=0.
  - ex_stall: all ex_* outputs hold; id_stall=1; FSM holds.
  - advance: capture id_* and the selected operands; ex_valid=id_valid.
- When id_valid=0, a bubble is loaded and the hazard check is suppressed.

## Timing
- Reset: ex_valid, ex_reg_write, ex_mem_read = 0; ex_rs1, ex_rs2, ex_rd = 0; ex_op1, ex_op2 = 0; FSM = RUN; id_stall = 0.
- Latency: 1 cycle, ID inputs to ex_* outputs.
- rf_rs* and id_stall are combinational. id_stall is asserted in the hazard cycle and whenever ex_stall is high.
- Writeback in the same cycle as the read is bypassed, so the regfile's write-after-read edge is never visible.
- Load-use costs exactly one bubble. Two back-to-back dependent loads cost one bubble each.
- A flush in the hazard cycle wins: no bubble state and no stall.
- A reset asserted mid-stall clears the FSM to RUN immediately.

## Configuration
- OPERAND_FETCH_WB_BYPASS_EN defined: same-cycle writeback bypass as described.
- Not defined: no bypass mux. A writeback/read index match (non-zero, on a used source) is treated like a hazard: one-cycle id_stall and bubble, with the FSM passing through BUBBLE. The next cycle reads the updated regfile.

## Structure
- A shared package holds XLEN, REGW, the FSM state enum (RUN, BUBBLE) and an ID/EX bundle typedef (valid, reg_write, mem_read, rs1, rs2, rd, op1, op2).
- One sub-module, hazard_detect: a combinational load-use compare, plus the writeback compare when bypass is disabled. The FSM and register stay in operand_fetch.

## Test plan
- Reset, then id_rs1=3 with regs[3]=0x11, id_rs2=0 -> after 1 cycle ex_op1=0x11, ex_op2=0, ex_valid=1.
- wb writes x5=0xDEAD in the same cycle ID reads rs1=5 -> ex_op1=0xDEAD (bypass on). With bypass off: one id_stall cycle, then ex_op1=0xDEAD.
- Load to x7 in EX, ID uses rs2=7 -> id_stall=1 for 1 cycle, bubble with ex_valid=0, then the instruction issues. With id_use_rs2=0 -> no stall.
- Load to x0 in EX with ID rs1=0 -> no stall. wb to x0 with value 0xFFFF -> ex_op1=0.
- ex_stall held 3 cycles -> ex_* outputs stable and id_stall=1 throughout. flush asserted during the hazard cycle -> ex_valid=0, FSM=RUN, no extra bubble.
- rst asserted during BUBBLE -> next cycle all outputs at reset values and FSM=RUN.
